// File: rtl/btn_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the pushbutton decoder:
//   - btn_state_t : press-tracking FSM encodings (IDLE / HELD / LONG)
//   - PI_*        : bit positions inside the registered event-pulse vector
//   - cnt_width() : width of a counter that must hold 0..n inclusive
// Optional feature macro used by the decoder: BTN_REPEAT_EN.
// ---------------------------------------------------------------------------
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } btn_state_t;

  // Event pulse vector layout
  localparam int PI_PRESS   = 0;
  localparam int PI_RELEASE = 1;
  localparam int PI_SHORT   = 2;
  localparam int PI_LONG    = 3;
  localparam int PULSE_W    = 4;

  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Front end of the pushbutton decoder: 2-FF synchroniser, polarity fix,
// free-running tick prescaler and debounce counter.
//
// Ports:
//   clk       in   LF oscillator clock
//   reset     in   synchronous active-high reset
//   btn_in    in   raw asynchronous button pin
//   btn_level out  debounced level, 1 = pressed (registered)
//   tick      out  one-cycle strobe every TICK_DIV clocks
//   rise      out  high in the cycle whose edge will set btn_level to 1
//   fall      out  high in the cycle whose edge will clear btn_level
//
// rise/fall are combinational look-ahead strobes so the decoder can register
// its event pulses on the same edge that updates btn_level.
// ---------------------------------------------------------------------------
module btn_debounce
  import btn_pkg::*;
#(
  parameter int TICK_DIV   = 10,
  parameter int DEB_TICKS  = 20,
  parameter int ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic tick,
  output logic rise,
  output logic fall
);

  localparam int   TW       = cnt_width(TICK_DIV);
  localparam int   DW       = cnt_width(DEB_TICKS);
  // Pin level when the button is not pressed
  localparam logic IDLE_PIN = (ACTIVE_LOW != 0);

  logic          sync1_reg;
  logic          sync2_reg;
  logic [TW-1:0] tick_cnt_reg;
  logic [DW-1:0] deb_cnt_reg;
  logic          level_reg;
  logic          p;
  logic          settle;

  assign p         = sync2_reg ^ IDLE_PIN;
  assign tick      = (tick_cnt_reg == TW'(TICK_DIV - 1));
  assign settle    = tick && (p != level_reg) && (deb_cnt_reg == DW'(DEB_TICKS - 1));
  assign rise      = settle && p;
  assign fall      = settle && !p;
  assign btn_level = level_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg    <= IDLE_PIN;
      sync2_reg    <= IDLE_PIN;
      tick_cnt_reg <= '0;
      deb_cnt_reg  <= '0;
      level_reg    <= 1'b0;
    end else begin
      sync1_reg <= btn_in;
      sync2_reg <= sync1_reg;

      if (tick) begin
        tick_cnt_reg <= '0;
      end else begin
        tick_cnt_reg <= tick_cnt_reg + 1'b1;
      end

      // Any cycle that agrees with the current level restarts the stability
      // window, so a bounce of fewer than DEB_TICKS ticks never gets through.
      if (p == level_reg) begin
        deb_cnt_reg <= '0;
      end else if (tick) begin
        if (deb_cnt_reg == DW'(DEB_TICKS - 1)) begin
          level_reg   <= p;
          deb_cnt_reg <= '0;
        end else begin
          deb_cnt_reg <= deb_cnt_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/button_decoder.sv
// ---------------------------------------------------------------------------
// button_decoder
// Decodes the board pushbutton into a debounced level plus one-cycle event
// pulses for the LED-state / mode-select logic.
//
// Ports:
//   clk           in   LF oscillator clock
//   reset         in   synchronous active-high reset
//   btn_in        in   raw asynchronous button pin
//   btn_level     out  debounced pressed level
//   press_pulse   out  debounced press
//   release_pulse out  every debounced release
//   short_pulse   out  release before the long threshold
//   long_pulse    out  long threshold reached while held
//   repeat_pulse  out  auto-repeat while long-held
//
// Optional feature: define BTN_REPEAT_EN to enable auto-repeat. Without it
// repeat_pulse is constant 0 and no repeat counter exists.
// ---------------------------------------------------------------------------
module button_decoder
  import btn_pkg::*;
#(
  parameter int TICK_DIV     = 10,
  parameter int DEB_TICKS    = 20,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 250,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int HW = cnt_width(LONG_TICKS);

  generate
    if (TICK_DIV < 1 || DEB_TICKS < 1 || LONG_TICKS < 1 || REPEAT_TICKS < 1) begin : g_param_check
      $error("button_decoder: tick counts must all be at least 1");
    end
  endgenerate

  logic               tick;
  logic               deb_rise;
  logic               deb_fall;
  btn_state_t         state_reg;
  logic [HW-1:0]      hold_cnt_reg;
  logic [PULSE_W-1:0] pulse_reg;

  btn_debounce #(
    .TICK_DIV   (TICK_DIV),
    .DEB_TICKS  (DEB_TICKS),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .tick      (tick),
    .rise      (deb_rise),
    .fall      (deb_fall)
  );

  // Release is tested before the long threshold, so a release landing on
  // the threshold tick is reported as a short press.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      hold_cnt_reg <= '0;
      pulse_reg    <= '0;
    end else begin
      pulse_reg <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (deb_rise) begin
            state_reg           <= ST_HELD;
            hold_cnt_reg        <= '0;
            pulse_reg[PI_PRESS] <= 1'b1;
          end
        end
        ST_HELD: begin
          if (deb_fall) begin
            state_reg             <= ST_IDLE;
            pulse_reg[PI_RELEASE] <= 1'b1;
            pulse_reg[PI_SHORT]   <= 1'b1;
          end else if (tick) begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
            if (hold_cnt_reg == HW'(LONG_TICKS - 1)) begin
              state_reg          <= ST_LONG;
              pulse_reg[PI_LONG] <= 1'b1;
            end
          end
        end
        ST_LONG: begin
          if (deb_fall) begin
            state_reg             <= ST_IDLE;
            pulse_reg[PI_RELEASE] <= 1'b1;
          end else if (tick && (hold_cnt_reg != HW'(LONG_TICKS))) begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign press_pulse   = pulse_reg[PI_PRESS];
  assign release_pulse = pulse_reg[PI_RELEASE];
  assign short_pulse   = pulse_reg[PI_SHORT];
  assign long_pulse    = pulse_reg[PI_LONG];

`ifdef BTN_REPEAT_EN
  localparam int RW = cnt_width(REPEAT_TICKS);

  logic [RW-1:0] rpt_cnt_reg;
  logic          rpt_pulse_reg;

  // rpt_cnt is held at 0 outside LONG, so it is already clear on entry and
  // the entry tick itself is not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_cnt_reg   <= '0;
      rpt_pulse_reg <= 1'b0;
    end else begin
      rpt_pulse_reg <= 1'b0;
      if (state_reg != ST_LONG || deb_fall) begin
        rpt_cnt_reg <= '0;
      end else if (tick) begin
        if (rpt_cnt_reg == RW'(REPEAT_TICKS - 1)) begin
          rpt_cnt_reg   <= '0;
          rpt_pulse_reg <= 1'b1;
        end else begin
          rpt_cnt_reg <= rpt_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign repeat_pulse = rpt_pulse_reg;
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule
